// File: rtl/z_buffer_pkg.sv
// Shared definitions for the z_buffer depth-test stage: default field
// widths, pixel word layout, far-plane depth and the controller state set.
package z_buffer_pkg;

    localparam int DEF_ADDR_WIDTH  = 4;
    localparam int DEF_DEPTH_WIDTH = 6;
    localparam int DEF_COLOR_WIDTH = 6;
    localparam int DEF_PIXEL_WIDTH = DEF_ADDR_WIDTH + DEF_DEPTH_WIDTH + DEF_COLOR_WIDTH;
    localparam int DEF_CNT_WIDTH   = 16;

    // Pixel word layout, LSB first: {addr, depth, color}
    localparam int COLOR_LSB = 0;
    localparam int DEPTH_LSB = COLOR_LSB + DEF_COLOR_WIDTH;
    localparam int ADDR_LSB  = DEPTH_LSB + DEF_DEPTH_WIDTH;

    // All-ones depth marks an empty (far plane) entry
    localparam logic [DEF_DEPTH_WIDTH-1:0] FAR_DEPTH = {DEF_DEPTH_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_CLEAR   = 2'd0,
        ST_IDLE    = 2'd1,
        ST_COMPARE = 2'd2,
        ST_SCAN    = 2'd3
    } state_e;

endpackage

// File: rtl/z_buffer_if.sv
// Pixel input, control requests, scan-out handshake and statistics of the
// z_buffer stage. The master side is the upstream/consumer environment.
interface z_buffer_if
    import z_buffer_pkg::*;
#(
    parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int COLOR_WIDTH = DEF_COLOR_WIDTH,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) ();

    logic [PIXEL_WIDTH-1:0] pix_in;
    logic                   send_z_buffer;
    logic                   rdy_z_buffer;
    logic                   clear;
    logic                   scan_start;
    logic                   scan_valid;
    logic                   scan_ready;
    logic [ADDR_WIDTH-1:0]  scan_addr;
    logic [COLOR_WIDTH-1:0] scan_color;
    logic                   busy;
    logic [CNT_WIDTH-1:0]   cnt_written;
    logic [CNT_WIDTH-1:0]   cnt_rejected;

    modport slave (
        input  pix_in,
        input  send_z_buffer,
        output rdy_z_buffer,
        input  clear,
        input  scan_start,
        output scan_valid,
        input  scan_ready,
        output scan_addr,
        output scan_color,
        output busy,
        output cnt_written,
        output cnt_rejected
    );

    modport master (
        output pix_in,
        output send_z_buffer,
        input  rdy_z_buffer,
        output clear,
        output scan_start,
        input  scan_valid,
        output scan_ready,
        input  scan_addr,
        input  scan_color,
        input  busy,
        input  cnt_written,
        input  cnt_rejected
    );

endinterface

// File: rtl/z_buffer_mem.sv
// Depth and colour storage, one entry per screen address. Two combinational
// read ports (depth for the compare, colour for scan-out) and a single
// synchronous write port shared by frame clear and the depth-test update.
// The arrays carry no reset: every entry is rewritten by the clear sweep
// that follows any reset.
module z_buffer_mem #(
    parameter int ADDR_WIDTH  = 4,
    parameter int DEPTH_WIDTH = 6,
    parameter int COLOR_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   we_i,
    input  logic [ADDR_WIDTH-1:0]  waddr_i,
    input  logic [DEPTH_WIDTH-1:0] wdepth_i,
    input  logic [COLOR_WIDTH-1:0] wcolor_i,
    input  logic [ADDR_WIDTH-1:0]  cmp_addr_i,
    output logic [DEPTH_WIDTH-1:0] cmp_depth_o,
    input  logic [ADDR_WIDTH-1:0]  scan_addr_i,
    output logic [COLOR_WIDTH-1:0] scan_color_o
);

    localparam int ENTRIES = 2 ** ADDR_WIDTH;

    logic [DEPTH_WIDTH-1:0] depth_q [ENTRIES];
    logic [COLOR_WIDTH-1:0] color_q [ENTRIES];

    // Single write port: one entry updated per enabled clock edge
    always_ff @(posedge clk) begin
        if (we_i) begin
            depth_q[waddr_i] <= wdepth_i;
            color_q[waddr_i] <= wcolor_i;
        end
    end

    assign cmp_depth_o  = depth_q[cmp_addr_i];
    assign scan_color_o = color_q[scan_addr_i];

endmodule

// File: rtl/z_buffer.sv
// Depth-test stage. Accepts one pixel every two cycles, keeps it only when it
// is strictly nearer than the stored depth, sweeps the memories on frame
// clear and streams the colour memory out through a valid/ready handshake.
module z_buffer
    import z_buffer_pkg::*;
#(
    parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DEPTH_WIDTH = DEF_DEPTH_WIDTH,
    parameter int COLOR_WIDTH = DEF_COLOR_WIDTH,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic      clk,
    input  logic      reset,
    z_buffer_if.slave zb
);

    // Field offsets follow the configured widths, {addr, depth, color}
    localparam int C_OFF = COLOR_LSB;
    localparam int D_OFF = C_OFF + COLOR_WIDTH;
    localparam int A_OFF = D_OFF + DEPTH_WIDTH;

    localparam logic [DEPTH_WIDTH-1:0] FAR_D   = {DEPTH_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0]  IDX_MAX = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0]  IDX_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]   CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  idx_q, idx_d;
    logic                   pend_clear_q, pend_clear_d;
    logic [ADDR_WIDTH-1:0]  pix_addr_q, pix_addr_d;
    logic [DEPTH_WIDTH-1:0] pix_depth_q, pix_depth_d;
    logic [COLOR_WIDTH-1:0] pix_color_q, pix_color_d;
    logic [CNT_WIDTH-1:0]   cnt_written_q, cnt_written_d;
    logic [CNT_WIDTH-1:0]   cnt_rejected_q, cnt_rejected_d;

    logic                   rdy_s;
    logic                   mem_we_s;
    logic [ADDR_WIDTH-1:0]  mem_waddr_s;
    logic [DEPTH_WIDTH-1:0] mem_wdepth_s;
    logic [COLOR_WIDTH-1:0] mem_wcolor_s;
    logic [DEPTH_WIDTH-1:0] cmp_depth_s;
    logic [COLOR_WIDTH-1:0] scan_color_s;
    logic                   scan_active_s;

    z_buffer_mem #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DEPTH_WIDTH (DEPTH_WIDTH),
        .COLOR_WIDTH (COLOR_WIDTH)
    ) u_mem (
        .clk          (clk),
        .we_i         (mem_we_s),
        .waddr_i      (mem_waddr_s),
        .wdepth_i     (mem_wdepth_s),
        .wcolor_i     (mem_wcolor_s),
        .cmp_addr_i   (pix_addr_q),
        .cmp_depth_o  (cmp_depth_s),
        .scan_addr_i  (idx_q),
        .scan_color_o (scan_color_s)
    );

    // State, sweep index, captured pixel and statistics registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_CLEAR;
            idx_q          <= '0;
            pend_clear_q   <= 1'b0;
            pix_addr_q     <= '0;
            pix_depth_q    <= '0;
            pix_color_q    <= '0;
            cnt_written_q  <= '0;
            cnt_rejected_q <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            pend_clear_q   <= pend_clear_d;
            pix_addr_q     <= pix_addr_d;
            pix_depth_q    <= pix_depth_d;
            pix_color_q    <= pix_color_d;
            cnt_written_q  <= cnt_written_d;
            cnt_rejected_q <= cnt_rejected_d;
        end
    end

    // Next-state, memory write port and ready generation
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        pix_addr_d     = pix_addr_q;
        pix_depth_d    = pix_depth_q;
        pix_color_d    = pix_color_q;
        cnt_written_d  = cnt_written_q;
        cnt_rejected_d = cnt_rejected_q;
        rdy_s          = 1'b0;
        mem_we_s       = 1'b0;
        mem_waddr_s    = idx_q;
        mem_wdepth_s   = FAR_D;
        mem_wcolor_s   = '0;

        // A clear arriving while busy is remembered until the next IDLE cycle
        if (zb.clear && (state_q != ST_IDLE)) begin
            pend_clear_d = 1'b1;
        end else begin
            pend_clear_d = pend_clear_q;
        end

        case (state_q)
            ST_CLEAR: begin
                mem_we_s = 1'b1;
                if (idx_q == IDX_MAX) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                end
            end
            ST_IDLE: begin
                rdy_s = !zb.clear && !pend_clear_q && !zb.scan_start;
                if (zb.clear || pend_clear_q) begin
                    state_d        = ST_CLEAR;
                    idx_d          = '0;
                    pend_clear_d   = 1'b0;
                    cnt_written_d  = '0;
                    cnt_rejected_d = '0;
                end else if (zb.scan_start) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                end else if (zb.send_z_buffer) begin
                    state_d     = ST_COMPARE;
                    pix_addr_d  = zb.pix_in[A_OFF +: ADDR_WIDTH];
                    pix_depth_d = zb.pix_in[D_OFF +: DEPTH_WIDTH];
                    pix_color_d = zb.pix_in[C_OFF +: COLOR_WIDTH];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMPARE: begin
                state_d = ST_IDLE;
                // Strictly nearer wins; an equal depth keeps the earlier pixel
                if (pix_depth_q < cmp_depth_s) begin
                    mem_we_s      = 1'b1;
                    mem_waddr_s   = pix_addr_q;
                    mem_wdepth_s  = pix_depth_q;
                    mem_wcolor_s  = pix_color_q;
                    cnt_written_d = (cnt_written_q == CNT_MAX) ? cnt_written_q
                                                               : cnt_written_q + CNT_ONE;
                end else begin
                    cnt_rejected_d = (cnt_rejected_q == CNT_MAX) ? cnt_rejected_q
                                                                 : cnt_rejected_q + CNT_ONE;
                end
            end
            ST_SCAN: begin
                if (zb.scan_ready) begin
                    if (idx_q == IDX_MAX) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    assign scan_active_s   = (state_q == ST_SCAN);

    assign zb.rdy_z_buffer = rdy_s;
    assign zb.busy         = (state_q != ST_IDLE);
    assign zb.scan_valid   = scan_active_s;
    assign zb.scan_addr    = scan_active_s ? idx_q : '0;
    assign zb.scan_color   = scan_active_s ? scan_color_s : '0;
    assign zb.cnt_written  = cnt_written_q;
    assign zb.cnt_rejected = cnt_rejected_q;

endmodule

// File: tb/tb_z_buffer.sv
// Directed self-checking bench for z_buffer. Inputs change 1ns after the
// rising edge and outputs are observed there as well, away from the edge.
module tb_z_buffer;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    z_buffer_if zif ();

    z_buffer dut (
        .clk   (clk),
        .reset (reset),
        .zb    (zif)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [5:0] scan_mem [16];
    int         scan_count;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        zif.pix_in        = 16'h0000;
        zif.send_z_buffer = 1'b0;
        zif.clear         = 1'b0;
        zif.scan_start    = 1'b0;
        zif.scan_ready    = 1'b1;
    endtask

    task automatic send_pixel(input logic [15:0] pix, input string name);
        int guard;
        guard = 0;
        zif.pix_in        = pix;
        zif.send_z_buffer = 1'b1;
        #1;
        while (zif.rdy_z_buffer !== 1'b1 && guard < 40) begin
            tick();
            guard++;
        end
        tests_run++;
        if (zif.rdy_z_buffer !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s: rdy_z_buffer=%b, required 1", name, zif.rdy_z_buffer);
        end
        tick();
        zif.send_z_buffer = 1'b0;
        tick();
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (zif.busy === 1'b1 && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    task automatic do_clear(input string name);
        int cyc;
        zif.clear = 1'b1;
        #1;
        tick();
        zif.clear = 1'b0;
        wait_idle(cyc);
        tests_run++;
        if (cyc != 16) begin
            tests_failed++;
            $display("FAIL %s: clear took %0d cycles, required 16", name, cyc);
        end
    endtask

    task automatic scan_all(input string name);
        int guard;
        for (int i = 0; i < 16; i++) scan_mem[i] = 6'bxxxxxx;
        scan_count        = 0;
        guard             = 0;
        zif.scan_ready    = 1'b1;
        zif.scan_start    = 1'b1;
        tick();
        zif.scan_start    = 1'b0;
        while (zif.scan_valid === 1'b1 && guard < 40) begin
            tests_run++;
            if (zif.scan_addr !== scan_count[3:0]) begin
                tests_failed++;
                $display("FAIL %s_addr: scan_addr=%0d, required %0d", name, zif.scan_addr, scan_count);
            end
            scan_mem[zif.scan_addr] = zif.scan_color;
            scan_count++;
            guard++;
            tick();
        end
        tests_run++;
        if (scan_count != 16 || zif.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_len: transfers=%0d busy=%b, required 16 and 0", name, scan_count, zif.busy);
        end
    endtask

    task automatic check_counts(input string name, input logic [15:0] w, input logic [15:0] r);
        tests_run++;
        if (zif.cnt_written !== w || zif.cnt_rejected !== r) begin
            tests_failed++;
            $display("FAIL %s: written=%0d rejected=%0d, required %0d %0d",
                     name, zif.cnt_written, zif.cnt_rejected, w, r);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tests_run++;
            if (zif.rdy_z_buffer !== 1'b0 || zif.busy !== 1'b1 || zif.scan_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_clear[%0d]: rdy=%b busy=%b scan_valid=%b, required 0 1 0",
                         i, zif.rdy_z_buffer, zif.busy, zif.scan_valid);
            end
            tick();
        end
        tests_run++;
        if (zif.rdy_z_buffer !== 1'b1 || zif.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: rdy=%b busy=%b, required 1 0", zif.rdy_z_buffer, zif.busy);
        end
        check_counts("reset_counts", 16'd0, 16'd0);
    endtask

    task automatic test_depth();
        logic [5:0] exp;
        send_pixel(16'h3295, "depth_p1");
        send_pixel(16'h352A, "depth_p2");
        send_pixel(16'h3141, "depth_p3");
        check_counts("depth_counts", 16'd2, 16'd1);
        scan_all("depth_scan");
        for (int i = 0; i < 16; i++) begin
            exp = (i == 3) ? 6'h01 : 6'h00;
            tests_run++;
            if (scan_mem[i] !== exp) begin
                tests_failed++;
                $display("FAIL depth_color[%0d]: color=%h, required %h", i, scan_mem[i], exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        int   k;
        logic exp_rdy;
        do_clear("b2b_clear");
        check_counts("b2b_zeroed", 16'd0, 16'd0);
        k                 = 0;
        zif.pix_in        = 16'h0001;
        zif.send_z_buffer = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            exp_rdy = ((c % 2) == 0);
            tests_run++;
            if (zif.rdy_z_buffer !== exp_rdy) begin
                tests_failed++;
                $display("FAIL b2b_rdy[%0d]: rdy=%b, required %b", c, zif.rdy_z_buffer, exp_rdy);
            end
            tick();
            if ((c % 2) == 0) begin
                k++;
                if (k < 4) zif.pix_in = 16'h0001 + k[15:0];
                else zif.send_z_buffer = 1'b0;
            end
        end
        check_counts("b2b_counts", 16'd1, 16'd3);
        scan_all("b2b_scan");
        tests_run++;
        if (scan_mem[0] !== 6'h01) begin
            tests_failed++;
            $display("FAIL b2b_color0: color=%h, required 01", scan_mem[0]);
        end
    endtask

    task automatic test_clear_collision();
        int cyc;
        zif.pix_in        = 16'h3295;
        zif.send_z_buffer = 1'b1;
        zif.clear         = 1'b1;
        #1;
        tests_run++;
        if (zif.rdy_z_buffer !== 1'b0) begin
            tests_failed++;
            $display("FAIL coll_rdy: rdy=%b, required 0", zif.rdy_z_buffer);
        end
        tick();
        zif.clear         = 1'b0;
        zif.send_z_buffer = 1'b0;
        check_counts("coll_zeroed", 16'd0, 16'd0);
        wait_idle(cyc);
        tests_run++;
        if (cyc != 16) begin
            tests_failed++;
            $display("FAIL coll_cycles: clear took %0d cycles, required 16", cyc);
        end
        check_counts("coll_after_clear", 16'd0, 16'd0);
        send_pixel(16'h3295, "coll_resend");
        check_counts("coll_resend_counts", 16'd1, 16'd0);
    endtask

    task automatic test_scan_stall();
        int   guard;
        int   n;
        logic stalled;
        logic [5:0] exp;
        send_pixel(16'h506C, "stall_px");
        check_counts("stall_counts", 16'd2, 16'd0);
        n              = 0;
        guard          = 0;
        stalled        = 1'b0;
        zif.scan_ready = 1'b1;
        zif.scan_start = 1'b1;
        tick();
        zif.scan_start = 1'b0;
        while (zif.scan_valid === 1'b1 && guard < 60) begin
            guard++;
            if (zif.scan_addr === 4'd5 && !stalled) begin
                stalled = 1'b1;
                for (int s = 0; s < 3; s++) begin
                    zif.scan_ready = 1'b0;
                    #1;
                    tests_run++;
                    if (zif.scan_valid !== 1'b1 || zif.scan_addr !== 4'd5 || zif.scan_color !== 6'h2C) begin
                        tests_failed++;
                        $display("FAIL stall_hold[%0d]: valid=%b addr=%0d color=%h, required 1 5 2c",
                                 s, zif.scan_valid, zif.scan_addr, zif.scan_color);
                    end
                    tick();
                end
                zif.scan_ready = 1'b1;
            end
            #1;
            exp = (n == 3) ? 6'h15 : ((n == 5) ? 6'h2C : 6'h00);
            tests_run++;
            if (zif.scan_addr !== n[3:0] || zif.scan_color !== exp) begin
                tests_failed++;
                $display("FAIL stall_xfer[%0d]: addr=%0d color=%h, required %0d %h",
                         n, zif.scan_addr, zif.scan_color, n, exp);
            end
            n++;
            tick();
        end
        tests_run++;
        if (n != 16 || zif.busy !== 1'b0 || zif.scan_valid !== 1'b0 || !stalled) begin
            tests_failed++;
            $display("FAIL stall_end: transfers=%0d busy=%b valid=%b stalled=%b, required 16 0 0 1",
                     n, zif.busy, zif.scan_valid, stalled);
        end
    endtask

    task automatic test_reset_mid_compare();
        int cyc;
        do_clear("rst_pre_clear");
        send_pixel(16'h3295, "rst_p1");
        zif.pix_in        = 16'h3141;
        zif.send_z_buffer = 1'b1;
        #1;
        tests_run++;
        if (zif.rdy_z_buffer !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_accept: rdy=%b, required 1", zif.rdy_z_buffer);
        end
        tick();
        reset             = 1'b1;
        zif.send_z_buffer = 1'b0;
        #1;
        tests_run++;
        if (zif.busy !== 1'b1 || zif.rdy_z_buffer !== 1'b0 || zif.cnt_written !== 16'd0) begin
            tests_failed++;
            $display("FAIL rst_abort: busy=%b rdy=%b written=%0d, required 1 0 0",
                     zif.busy, zif.rdy_z_buffer, zif.cnt_written);
        end
        tick();
        tick();
        reset = 1'b0;
        wait_idle(cyc);
        tests_run++;
        if (cyc != 16) begin
            tests_failed++;
            $display("FAIL rst_clear_cycles: %0d cycles, required 16", cyc);
        end
        check_counts("rst_counts", 16'd0, 16'd0);
        scan_all("rst_scan");
        tests_run++;
        if (scan_mem[3] !== 6'h00) begin
            tests_failed++;
            $display("FAIL rst_color3: color=%h, required 00", scan_mem[3]);
        end
        // depth 62 only passes if addr 3 holds the far plane again
        send_pixel(16'h3F87, "rst_probe");
        check_counts("rst_depth_far", 16'd1, 16'd0);
    endtask

    initial begin
        test_reset();
        test_depth();
        test_back_to_back();
        test_clear_collision();
        test_scan_stall();
        test_reset_mid_compare();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/z_buffer.md
Name: z_buffer

Overview:
- Depth-test stage directly downstream of fifo_contention_tree; consumes the arbitrated pixel stream on pix_in/send_z_buffer and returns rdy_z_buffer.
- Holds a depth memory and a colour memory, one entry per screen address.
- An incoming pixel overwrites its entry only if strictly nearer than the stored depth.
- Provides frame clear and a handshaked scan-out of the colour memory.

Parameters:
- PIXEL_WIDTH, 16, input pixel word width; must equal ADDR_WIDTH+DEPTH_WIDTH+COLOR_WIDTH.
- ADDR_WIDTH, 4, screen address width; memories hold 2**ADDR_WIDTH entries.
- DEPTH_WIDTH, 6, depth field width; all-ones is the far plane.
- COLOR_WIDTH, 6, colour field width.
- CNT_WIDTH, 16, statistics counter width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- pix_in  in  PIXEL_WIDTH  {addr[15:12], depth[11:6], color[5:0]} at defaults.
- send_z_buffer  in  1  pix_in valid (from contention tree).
- rdy_z_buffer  out  1  ready; pixel accepted on a clk edge with send_z_buffer && rdy_z_buffer.
- clear  in  1  one-cycle clear request.
- scan_start  in  1  start colour scan-out.
- scan_valid  out  1  scan word valid.
- scan_ready  in  1  scan consumer ready.
- scan_addr  out  ADDR_WIDTH  address of scan word.
- scan_color  out  COLOR_WIDTH  colour of scan word.
- busy  out  1  high in any state other than IDLE.
- cnt_written  out  CNT_WIDTH  pixels that passed the depth test.
- cnt_rejected  out  CNT_WIDTH  pixels that failed the depth test.

Behaviour:
- FSM states: CLEAR, IDLE, COMPARE, SCAN.
- Reset:
  - State -> CLEAR with clear index 0; rdy_z_buffer=0, scan_valid=0, scan_addr=0, scan_color=0.
  - busy=1; both counters 0; pending-clear flag 0.
- CLEAR:
  - One entry per cycle: depth <= all-ones, color <= 0; index increments.
  - After entry 2**ADDR_WIDTH-1 -> IDLE, giving 2**ADDR_WIDTH cycles total.
  - Counters are zeroed on CLEAR entry.
- IDLE:
  - rdy_z_buffer = (state==IDLE) && !clear && !pending_clear && !scan_start. This is combinational from registered state and the two request inputs.
  - Priority: clear/pending_clear -> CLEAR; else scan_start -> SCAN; else accept pixel.
  - A pixel is never accepted in the same cycle as clear or scan_start.
- Accept:
  - Register addr, depth and color fields -> COMPARE.
  - Throughput is 1 pixel per 2 cycles.
- COMPARE:
  - Read the stored depth combinationally.
  - If new depth < stored: write depth and color at the COMPARE->IDLE edge and increment cnt_written.
  - Otherwise increment cnt_rejected.
  - Equal depth is rejected (first pixel wins).
  - Counters saturate at all-ones.
  - Next state is IDLE; the memory update is visible to the next COMPARE.
- SCAN:
  - scan_valid=1, scan_addr=index, scan_color=color[index].
  - Index advances only on scan_valid && scan_ready.
  - Outputs are held stable while !scan_ready.
  - After the last address is transferred: scan_valid=0 -> IDLE.
- clear outside IDLE sets pending_clear. It is serviced on the next IDLE cycle and cleared on CLEAR entry.
- scan_start outside IDLE is ignored.
- Reset asserted mid-COMPARE or mid-SCAN: abort immediately; no partial write lands after reset deassertion; restart in CLEAR.

Decomposition:
- Shared package z_buffer_pkg:
  - field offset/width localparams (ADDR_LSB, DEPTH_LSB, COLOR_LSB);
  - FAR_DEPTH constant;
  - state enum (CLEAR, IDLE, COMPARE, SCAN).
- Sub-module z_buffer_mem:
  - register array holding depth and colour;
  - two async read ports (compare, scan) and one synchronous write port (used by CLEAR and COMPARE).
- FSM and counters live in z_buffer.

Test Plan:
- Reset pulse -> rdy_z_buffer=0 and busy=1 for 16 cycles; then rdy_z_buffer=1, busy=0, both counters 0.
- Send 0x3295 (addr 3, depth 10, color 0x15), then 0x352A (depth 20), then 0x3141 (depth 5) -> cnt_written=2, cnt_rejected=1. Scan then yields addr 3 color 0x01 and color 0 at every other address.
- Stream 0x0001..0x0004 as arbitrated by the tree, with send_z_buffer held high -> rdy toggles every other cycle; cnt_written=1, cnt_rejected=3; scan addr 0 = 0x01.
- clear and send_z_buffer (0x3295) in the same IDLE cycle -> rdy_z_buffer=0, pixel not accepted, 16-cycle CLEAR, counters 0. Resending the pixel after CLEAR is accepted.
- Scan with scan_ready low for 3 cycles at addr 5 -> scan_addr=5 and scan_color held stable. Exactly 16 transfers complete, then IDLE.
- Reset asserted during COMPARE of 0x3141 over stored depth 10 -> after reset, addr 3 reads depth 63 and color 0.
